// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - word requester port of the data memory arbiter
// One instance per requester; the arbiter takes the slave side.
interface dmem_arbiter_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;
  logic        err;

  modport master (output req, we, addr, wdata, input ack, rdata, err);
  modport slave  (input req, we, addr, wdata, output ack, rdata, err);
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - CPU-priority arbiter for the single-port data memory
// One transaction at a time: grant in IDLE, then WRITE or READ, then a one-cycle RESP ack.
module dmem_arbiter #(
  parameter int RD_LAT       = 2,
  parameter int STARVE_LIMIT = 4,
  parameter int ALIGN_CHECK  = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  dmem_arbiter_if.slave  c,
  dmem_arbiter_if.slave  d,
  output logic [31:0]    mem_addr,
  output logic [31:0]    mem_wdata,
  output logic           mem_we,
  output logic           mem_re,
  input  logic [31:0]    mem_rdata,
  output logic           busy
);

  localparam int LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

  state_t        state, next_state;
  logic          owner_dma;
  logic          err_q;
  logic [LW-1:0] lat_cnt;
  logic [SW-1:0] streak;
  logic [31:0]   c_rdata_q, d_rdata_q;

  logic          grant_c, grant_d, misaligned, sel_we;
  logic [31:0]   sel_addr, sel_wdata;

  always_comb begin
    next_state = state;
    grant_c    = 1'b0;
    grant_d    = 1'b0;
    misaligned = 1'b0;
    sel_we     = 1'b0;
    sel_addr   = 32'd0;
    sel_wdata  = 32'd0;
    case (state)
      IDLE: begin
        // DMA is forced in once the CPU has won STARVE_LIMIT grants in a row against it
        if (d.req && (!c.req || streak == SW'(STARVE_LIMIT))) grant_d = 1'b1;
        else if (c.req)                                       grant_c = 1'b1;
        sel_we     = grant_d ? d.we    : c.we;
        sel_addr   = grant_d ? d.addr  : c.addr;
        sel_wdata  = grant_d ? d.wdata : c.wdata;
        misaligned = (ALIGN_CHECK != 0) && (sel_addr[1:0] != 2'b00);
        if (grant_c || grant_d)
          next_state = misaligned ? RESP : (sel_we ? WRITE : READ);
      end
      WRITE:   next_state = RESP;
      READ:    if (lat_cnt == '0) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner_dma <= 1'b0;
      err_q     <= 1'b0;
      lat_cnt   <= '0;
      streak    <= '0;
      c_rdata_q <= 32'd0;
      d_rdata_q <= 32'd0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
    end else begin
      state <= next_state;
      if (grant_c || grant_d) begin
        owner_dma <= grant_d;
        err_q     <= misaligned;
        lat_cnt   <= LW'(RD_LAT - 1);
        // A rejected request never reaches the memory bus
        if (!misaligned) begin
          mem_addr  <= sel_addr;
          mem_wdata <= sel_wdata;
        end
        if (grant_d || !d.req)
          streak <= '0;
        else if (streak != SW'(STARVE_LIMIT))
          streak <= streak + SW'(1);
      end
      if (state == READ) begin
        if (lat_cnt == '0) begin
          if (owner_dma) d_rdata_q <= mem_rdata;
          else           c_rdata_q <= mem_rdata;
        end else begin
          lat_cnt <= lat_cnt - LW'(1);
        end
      end
    end
  end

  assign mem_we  = (state == WRITE);
  assign mem_re  = (state == READ);
  assign busy    = (state != IDLE);

  assign c.ack   = (state == RESP) && !owner_dma;
  assign d.ack   = (state == RESP) &&  owner_dma;
  assign c.err   = c.ack && err_q;
  assign d.err   = d.ack && err_q;
  assign c.rdata = c_rdata_q;
  assign d.rdata = d_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
// Inputs change and outputs are sampled on the falling edge.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        preload = 1'b1;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we, mem_re, busy;
  logic [31:0] mem [0:255];

  int errors = 0;
  int checks = 0;

  dmem_arbiter_if c_if ();
  dmem_arbiter_if d_if ();

  dmem_arbiter #(.RD_LAT(2), .STARVE_LIMIT(4), .ALIGN_CHECK(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .c         (c_if),
    .d         (d_if),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
      mem[8]  <= 32'hCAFEF00D;
      mem[12] <= 32'h11111111;
    end else if (mem_we) begin
      mem[mem_addr[9:2]] <= mem_wdata;
    end
  end
  assign mem_rdata = mem[mem_addr[9:2]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Starts at a falling edge in IDLE; returns at the falling edge of the ack cycle.
  task automatic txn(input bit dma, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                     output int lat, output logic err, output bit saw_we, output bit saw_re,
                     output bit saw_other);
    lat = -1; err = 1'bx; saw_we = 0; saw_re = 0; saw_other = 0;
    if (dma) begin d_if.req = 1; d_if.we = we; d_if.addr = addr; d_if.wdata = wdata; end
    else     begin c_if.req = 1; c_if.we = we; c_if.addr = addr; c_if.wdata = wdata; end
    for (int cyc = 1; cyc <= 20 && lat < 0; cyc++) begin
      @(negedge clk);
      saw_we |= mem_we;
      saw_re |= mem_re;
      saw_other |= dma ? c_if.ack : d_if.ack;
      if (dma ? d_if.ack : c_if.ack) begin
        lat = cyc;
        err = dma ? d_if.err : c_if.err;
      end
    end
    c_if.req = 0;
    d_if.req = 0;
  endtask

  int   lat;
  logic err;
  bit   s_we, s_re, s_oth, any_ack;
  bit   seq [0:9];
  int   n;

  initial begin
    c_if.req = 0; c_if.we = 0; c_if.addr = 0; c_if.wdata = 0;
    d_if.req = 0; d_if.we = 0; d_if.addr = 0; d_if.wdata = 0;

    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_re", mem_re, 0);
    chk("rst_c_ack", c_if.ack, 0);
    chk("rst_d_ack", d_if.ack, 0);
    chk("rst_c_rdata", c_if.rdata, 0);
    chk("rst_mem_addr", mem_addr, 0);
    preload = 0;
    rst_n = 1;

    // CPU store
    @(negedge clk);
    c_if.req = 1; c_if.we = 1; c_if.addr = 32'h10; c_if.wdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("st_mem_we", mem_we, 1);
    chk("st_mem_addr", mem_addr, 32'h10);
    chk("st_mem_wdata", mem_wdata, 32'hDEADBEEF);
    chk("st_c_ack_c1", c_if.ack, 0);
    @(negedge clk);
    chk("st_c_ack", c_if.ack, 1);
    chk("st_c_err", c_if.err, 0);
    chk("st_d_ack", d_if.ack, 0);
    chk("st_mem_we_c2", mem_we, 0);
    c_if.req = 0;
    @(negedge clk);
    chk("st_mem_word", mem[4], 32'hDEADBEEF);
    chk("st_busy_idle", busy, 0);

    // CPU load, two-cycle read latency
    c_if.req = 1; c_if.we = 0; c_if.addr = 32'h20;
    @(negedge clk);
    chk("ld_mem_re_c1", mem_re, 1);
    chk("ld_c_ack_c1", c_if.ack, 0);
    @(negedge clk);
    chk("ld_mem_re_c2", mem_re, 1);
    chk("ld_c_ack_c2", c_if.ack, 0);
    @(negedge clk);
    chk("ld_c_ack", c_if.ack, 1);
    chk("ld_mem_re_c3", mem_re, 0);
    chk("ld_c_rdata", c_if.rdata, 32'hCAFEF00D);
    c_if.req = 0;
    @(negedge clk);
    chk("ld_c_rdata_hold", c_if.rdata, 32'hCAFEF00D);

    // Simultaneous loads: CPU first, DMA in the cycle after c_ack
    c_if.req = 1; c_if.we = 0; c_if.addr = 32'h20;
    d_if.req = 1; d_if.we = 0; d_if.addr = 32'h40;
    repeat (3) @(negedge clk);
    chk("sim_c_ack", c_if.ack, 1);
    chk("sim_d_ack_c3", d_if.ack, 0);
    c_if.req = 0;
    @(negedge clk);
    chk("sim_idle_c4", busy, 0);
    @(negedge clk);
    chk("sim_d_mem_re", mem_re, 1);
    chk("sim_d_mem_addr", mem_addr, 32'h40);
    repeat (2) @(negedge clk);
    chk("sim_d_ack", d_if.ack, 1);
    chk("sim_d_rdata0", d_if.rdata, 0);
    d_if.req = 0;
    @(negedge clk);
    txn(1, 1, 32'h40, 32'h12345678, lat, err, s_we, s_re, s_oth);
    chk("dma_st_lat", 32'(lat), 2);
    chk("dma_st_err", err, 0);
    @(negedge clk);
    txn(1, 0, 32'h40, 0, lat, err, s_we, s_re, s_oth);
    chk("dma_ld_lat", 32'(lat), 3);
    chk("dma_ld_rdata", d_if.rdata, 32'h12345678);
    chk("dma_ld_c_rdata_kept", c_if.rdata, 32'hCAFEF00D);
    chk("dma_ld_no_c_ack", s_oth, 0);

    // Misaligned DMA store is rejected without a memory access
    @(negedge clk);
    txn(1, 1, 32'h13, 32'hFFFFFFFF, lat, err, s_we, s_re, s_oth);
    chk("mis_lat", 32'(lat), 1);
    chk("mis_err", err, 1);
    chk("mis_no_we", s_we, 0);
    chk("mis_no_re", s_re, 0);
    chk("mis_mem_word", mem[4], 32'hDEADBEEF);

    // Starvation: 4 CPU acks then 1 DMA ack, repeating
    @(negedge clk);
    c_if.req = 1; c_if.we = 1; c_if.addr = 32'h80; c_if.wdata = 32'h1;
    d_if.req = 1; d_if.we = 1; d_if.addr = 32'h84; d_if.wdata = 32'h2;
    n = 0;
    for (int cyc = 0; cyc < 80 && n < 10; cyc++) begin
      @(negedge clk);
      if (c_if.ack || d_if.ack) begin
        seq[n] = d_if.ack;
        n++;
      end
    end
    c_if.req = 0; d_if.req = 0;
    chk("starve_ack_count", 32'(n), 10);
    for (int i = 0; i < 10; i++)
      if (i < n) chk($sformatf("starve_ack%0d_is_dma", i), 32'(seq[i]), 32'((i % 5) == 4));

    // Reset during a CPU WRITE abandons it
    @(negedge clk);
    c_if.req = 1; c_if.we = 1; c_if.addr = 32'h30; c_if.wdata = 32'hBADC0DE0;
    @(negedge clk);
    chk("rw_mem_we_pre", mem_we, 1);
    #1 rst_n = 0;
    #1;
    chk("rw_mem_we_rst", mem_we, 0);
    chk("rw_busy_rst", busy, 0);
    c_if.req = 0;
    any_ack = 0;
    @(negedge clk);
    any_ack |= c_if.ack;
    rst_n = 1;
    repeat (3) begin
      @(negedge clk);
      any_ack |= c_if.ack | d_if.ack;
    end
    chk("rw_no_ack", any_ack, 0);
    chk("rw_busy_after", busy, 0);
    chk("rw_mem_word", mem[12], 32'h11111111);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
